mna_axil_arbiter: RTL and testbench
===================================

// Module: mna_axil_arbiter
// PURPOSE
// Shares one AXI4-Lite master port of the mesh (the slave side of an MNA) between N AXI4-Lite requesters.
// Round-robin arbitration; exactly one transaction (write or read) in flight at a time, so the single-outstanding
// NoC path never sees interleaving. Optional response timeout returns SLVERR if a NoC response never arrives.
// PARAMETERS
// N          2   number of requesters (>=2); GW = $clog2(N)
// ADDR_W     32  AXI4-Lite address width
// DATA_W     32  AXI4-Lite data width; strobe width DATA_W/8
// TIMEOUT    0   cycles waiting in WR_B/RD_R before SLVERR; 0 = disabled
// PORTS
// clk                        in   1                         clock, all logic rising-edge
// rst                        in   1                         synchronous reset, active-high
// s_aw{addr,prot,valid}      in   N*ADDR_W, N*3, N          requester write-address channels, packed, index i = bits [i*W +: W]
// s_w{data,strb,valid}       in   N*DATA_W, N*DATA_W/8, N   requester write-data channels
// s_ar{addr,prot,valid}      in   N*ADDR_W, N*3, N          requester read-address channels
// s_{b,r}ready               in   N each                    requester response readies
// s_{aw,w,ar}ready           out  N each                    requester channel readies
// s_b{resp,valid}            out  N*2, N                    requester write responses
// s_r{data,resp,valid}       out  N*DATA_W, N*2, N          requester read responses
// m_aw{addr,prot,valid}      out  ADDR_W, 3, 1              shared write address toward MNA
// m_w{data,strb,valid}       out  DATA_W, DATA_W/8, 1       shared write data
// m_ar{addr,prot,valid}      out  ADDR_W, 3, 1              shared read address
// m_{b,r}ready               out  1 each                    shared response readies
// m_{aw,w,ar}ready           in   1 each                    MNA channel readies
// m_b{resp,valid}, m_r{data,resp,valid}  in  2,1 / DATA_W,2,1  MNA responses
// grant_id                   out  GW                        registered index of current owner
// busy                       out  1                         1 whenever state != IDLE
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=0, wr_pref=1 (write first), grant_id=0, busy=0, every valid/ready output 0, payloads 0.
// - Request i: wr_req[i]=s_awvalid[i]; rd_req[i]=s_arvalid[i]. Requester eligible if wr_req|rd_req.
// - IDLE: pick first eligible index scanning rr_ptr, rr_ptr+1, ... mod N. Op = write if only wr_req, read if only rd_req,
//   else wr_pref. Register grant_id, go to WR_A or RD_A. Latency: request visible in cycle k -> m_awvalid/m_arvalid in k+1.
// - IDLE holds m_bready=m_rready=1: stale/late MNA responses are absorbed, never forwarded.
// - WR_A: mux s_aw*/s_w* of grant_id onto m_aw*/m_w*; s_awready[g]=m_awready, s_wready[g]=m_wready.
//   Flags aw_done, w_done set on each handshake; a done channel is then masked (valid and ready 0).
//   Both done (same or different cycles, any order) -> WR_B.
// - WR_B: s_bvalid[g]=m_bvalid, s_bresp[g]=m_bresp, m_bready=s_bready[g]. On handshake -> IDLE.
// - RD_A: mux s_ar* onto m_ar*; s_arready[g]=m_arready; handshake -> RD_R.
// - RD_R: s_r*[g]=m_r*, m_rready=s_rready[g]; handshake -> IDLE.
// - Completion (return to IDLE): rr_ptr = (g+1) mod N; wr_pref toggles. grant_id keeps last owner.
// - Non-granted requesters: all readies and valids 0 at all times; granted-but-other-op channels also 0.
// - Timeout (TIMEOUT>0): 16-bit counter cleared on entering WR_B/RD_R, +1 per cycle without m_*valid.
//   At count==TIMEOUT go to ERR: drive s_bvalid[g] (or s_rvalid[g], rdata=0) with resp=2'b10, m_*ready=0;
//   requester handshake -> IDLE (late response later absorbed in IDLE).
// - Responses pass combinationally; no buffering; hold while requester not ready (AXI stability inherited).
// - rst mid-transaction: next cycle full reset state; in-flight transaction abandoned (MNA shares rst).
// TESTING
// - s0 writes 0x11000011 @0x50000000 -> m_aw/m_w carry same values 1 cycle after request; s0 bresp=OKAY; s1 readies 0.
// - s0 and s1 issue writes in same cycle after reset -> s0 served first (grant_id 0), then s1 (grant_id 1); no overlap.
// - s1 reads @0x50000004 while s0 write in WR_B -> read waits; after s0 bvalid, s1 rdata=0x22000022 via s1 only.
// - s0 asserts awvalid and arvalid together twice -> write, read, write, read order (wr_pref alternates).
// - W presented 3 cycles before AW, then AW -> single m_w handshake, single m_aw handshake, WR_B reached once.
// - TIMEOUT=16, MNA never asserts bvalid -> s0 bresp=2'b10 after 16 cycles; later m_bvalid dropped, no s_bvalid;
//   rst raised in RD_R -> next cycle busy=0, all valids 0, grant_id 0.

Source files
------------

// File: rtl/mna_axil_arbiter.sv
// rtl/mna_axil_arbiter.sv - round-robin N:1 AXI4-Lite arbiter, one transaction in flight
module mna_axil_arbiter #(
  parameter int N       = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0,
  localparam int GW     = $clog2(N),
  localparam int SW     = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*ADDR_W-1:0] s_awaddr,
  input  logic [N*3-1:0]      s_awprot,
  input  logic [N-1:0]        s_awvalid,
  output logic [N-1:0]        s_awready,
  input  logic [N*DATA_W-1:0] s_wdata,
  input  logic [N*SW-1:0]     s_wstrb,
  input  logic [N-1:0]        s_wvalid,
  output logic [N-1:0]        s_wready,
  output logic [N*2-1:0]      s_bresp,
  output logic [N-1:0]        s_bvalid,
  input  logic [N-1:0]        s_bready,
  input  logic [N*ADDR_W-1:0] s_araddr,
  input  logic [N*3-1:0]      s_arprot,
  input  logic [N-1:0]        s_arvalid,
  output logic [N-1:0]        s_arready,
  output logic [N*DATA_W-1:0] s_rdata,
  output logic [N*2-1:0]      s_rresp,
  output logic [N-1:0]        s_rvalid,
  input  logic [N-1:0]        s_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [SW-1:0]       m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_A, RD_R, WR_ERR, RD_ERR} state_t;

  state_t        state, state_n;
  logic [GW-1:0] rr_ptr, rr_ptr_n, grant_n, pick;
  logic          wr_pref, wr_pref_n;
  logic          aw_done, aw_done_n, w_done, w_done_n;
  logic [15:0]   tcnt, tcnt_n;
  logic          found, pick_wr, aw_hs, w_hs, complete, timed_out;
  int            idx;
  int            g;

  assign g         = int'(grant_id);
  assign busy      = (state != IDLE);
  assign timed_out = (TIMEOUT != 0) && (tcnt == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      wr_pref  <= 1'b1;
      grant_id <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      tcnt     <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      wr_pref  <= wr_pref_n;
      grant_id <= grant_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      tcnt     <= tcnt_n;
    end
  end

  // First eligible requester scanning upward from rr_ptr, wrapping at N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int j = 0; j < N; j++) begin
      idx = (int'(rr_ptr) + j) % N;
      if (!found && (s_awvalid[idx] || s_arvalid[idx])) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
    pick_wr = s_awvalid[pick] && (!s_arvalid[pick] || wr_pref);
  end

  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    wr_pref_n = wr_pref;
    grant_n   = grant_id;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    tcnt_n    = tcnt;
    complete  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bresp   = '0;
    s_bvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rvalid  = '0;
    m_awaddr  = '0;
    m_awprot  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_araddr  = '0;
    m_arprot  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state)
      IDLE: begin
        // Late responses from an abandoned or timed-out transaction are swallowed here.
        m_bready = 1'b1;
        m_rready = 1'b1;
        if (found) begin
          grant_n   = pick;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = pick_wr ? WR_A : RD_A;
        end
      end
      WR_A: begin
        m_awaddr     = s_awaddr[g*ADDR_W +: ADDR_W];
        m_awprot     = s_awprot[g*3 +: 3];
        m_wdata      = s_wdata[g*DATA_W +: DATA_W];
        m_wstrb      = s_wstrb[g*SW +: SW];
        m_awvalid    = s_awvalid[g] && !aw_done;
        m_wvalid     = s_wvalid[g] && !w_done;
        s_awready[g] = m_awready && !aw_done;
        s_wready[g]  = m_wready && !w_done;
        aw_hs        = m_awvalid && m_awready;
        w_hs         = m_wvalid && m_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_n   = WR_B;
          tcnt_n    = '0;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end else begin
          aw_done_n = aw_done || aw_hs;
          w_done_n  = w_done || w_hs;
        end
      end
      WR_B: begin
        s_bvalid[g]       = m_bvalid;
        s_bresp[g*2 +: 2] = m_bresp;
        m_bready          = s_bready[g];
        if (m_bvalid && s_bready[g]) complete = 1'b1;
        else if (!m_bvalid) begin
          if (timed_out) state_n = WR_ERR;
          else tcnt_n = tcnt + 16'd1;
        end
      end
      RD_A: begin
        m_araddr     = s_araddr[g*ADDR_W +: ADDR_W];
        m_arprot     = s_arprot[g*3 +: 3];
        m_arvalid    = s_arvalid[g];
        s_arready[g] = m_arready;
        if (s_arvalid[g] && m_arready) begin
          state_n = RD_R;
          tcnt_n  = '0;
        end
      end
      RD_R: begin
        s_rvalid[g]                 = m_rvalid;
        s_rdata[g*DATA_W +: DATA_W] = m_rdata;
        s_rresp[g*2 +: 2]           = m_rresp;
        m_rready                    = s_rready[g];
        if (m_rvalid && s_rready[g]) complete = 1'b1;
        else if (!m_rvalid) begin
          if (timed_out) state_n = RD_ERR;
          else tcnt_n = tcnt + 16'd1;
        end
      end
      WR_ERR: begin
        s_bvalid[g]       = 1'b1;
        s_bresp[g*2 +: 2] = 2'b10;
        if (s_bready[g]) complete = 1'b1;
      end
      RD_ERR: begin
        s_rvalid[g]       = 1'b1;
        s_rresp[g*2 +: 2] = 2'b10;
        if (s_rready[g]) complete = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (complete) begin
      state_n   = IDLE;
      rr_ptr_n  = (g == N - 1) ? '0 : GW'(g + 1);
      wr_pref_n = !wr_pref;
    end
  end

endmodule

// File: tb/tb_mna_axil_arbiter.sv
// tb/tb_mna_axil_arbiter.sv - scoreboard bench for mna_axil_arbiter with a small MNA responder model
module tb_mna_axil_arbiter;

  logic        clk, rst;
  logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [5:0]  s_awprot, s_arprot;
  logic [7:0]  s_wstrb;
  logic [3:0]  s_bresp, s_rresp;
  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [0:0]  grant_id;
  logic        busy;

  mna_axil_arbiter #(.N(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct { bit is_rd; int gid; logic [31:0] addr; } a_t;
  typedef struct { int id; bit is_rd; logic [1:0] resp; logic [31:0] data; } r_t;

  a_t          exp_a[$];
  logic [31:0] exp_w[$];
  r_t          exp_r[$];
  int checks = 0, failures = 0;
  int cyc = 0, a_hs_cyc = 0, resp_delay = 0;
  int aw_cnt = 0, w_cnt = 0, resp_cnt = 0;
  bit inflight = 0, mute_b = 0, mute_r = 0;
  logic [31:0] mem [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int id, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_a.push_back('{1'b0, id, addr});
    exp_w.push_back(data);
    exp_r.push_back('{id, 1'b0, resp, 32'h0});
  endtask

  task automatic exp_rd(input int id, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_a.push_back('{1'b1, id, addr});
    exp_r.push_back('{id, 1'b1, resp, data});
  endtask

  // Requester master: W may lead AW by w_lead cycles; returns once every issued channel handshook.
  task automatic req(input int id, input bit do_wr, input bit do_rd, input logic [31:0] waddr,
                     input logic [31:0] wdata, input logic [31:0] raddr, input int w_lead);
    bit aw_left, w_left, ar_left;
    int lead, n;
    aw_left = do_wr; w_left = do_wr; ar_left = do_rd; lead = w_lead; n = 0;
    @(posedge clk); #1;
    s_awaddr[id*32 +: 32] = waddr;  s_awprot[id*3 +: 3] = 3'b000;
    s_wdata[id*32 +: 32]  = wdata;  s_wstrb[id*4 +: 4]  = 4'hf;
    s_araddr[id*32 +: 32] = raddr;  s_arprot[id*3 +: 3] = 3'b000;
    s_awvalid[id] = aw_left && (lead == 0);
    s_wvalid[id]  = w_left;
    s_arvalid[id] = ar_left;
    while ((aw_left || w_left || ar_left) && n < 300) begin
      @(negedge clk);
      if (s_awvalid[id] && s_awready[id]) aw_left = 1'b0;
      if (s_wvalid[id] && s_wready[id]) w_left = 1'b0;
      if (s_arvalid[id] && s_arready[id]) ar_left = 1'b0;
      @(posedge clk); #1;
      if (lead > 0) lead--;
      s_awvalid[id] = aw_left && (lead == 0);
      s_wvalid[id]  = w_left;
      s_arvalid[id] = ar_left;
      n++;
    end
    chk($sformatf("req%0d_accepted_within_budget", id), 64'(n < 300), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_r.size() != 0) && n < 400);
    chk("drain_within_budget", 64'(n < 400), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    chk("rst_s_outs", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 64'd0);
    chk("rst_payloads", {m_awaddr, m_wdata}, 64'd0);
    aw_cnt = 0; w_cnt = 0; resp_cnt = 0;
  endtask

  // MNA responder: accepts every address/data beat, answers two cycles later unless muted.
  initial begin
    bit rs, awf, wf, af, bf, rf, have_aw, have_w, bpend, rpend;
    logic [31:0] cap_a, cap_d, cap_r, waddr, wdat, raddr;
    int bcnt, rcnt;
    have_aw = 0; have_w = 0; bpend = 0; rpend = 0; bcnt = 0; rcnt = 0;
    cap_a = 0; cap_d = 0; cap_r = 0; waddr = 0; wdat = 0; raddr = 0;
    mem[32'h50000004] = 32'h22000022;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(negedge clk);
      rs = rst;
      awf = m_awvalid && m_awready; wf = m_wvalid && m_wready; af = m_arvalid && m_arready;
      bf = m_bvalid && m_bready;    rf = m_rvalid && m_rready;
      if (awf) cap_a = m_awaddr;
      if (wf) cap_d = m_wdata;
      if (af) cap_r = m_araddr;
      @(posedge clk); #1;
      if (rs) begin
        have_aw = 0; have_w = 0; bpend = 0; rpend = 0;
        m_bvalid = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      end else begin
        if (awf) begin have_aw = 1; waddr = cap_a; end
        if (wf) begin have_w = 1; wdat = cap_d; end
        if (have_aw && have_w) begin
          mem[waddr] = wdat; have_aw = 0; have_w = 0; bpend = 1; bcnt = 2;
        end
        if (bf) m_bvalid = 1'b0;
        if (bpend && !mute_b) begin
          if (bcnt == 0) begin m_bvalid = 1'b1; m_bresp = 2'b00; bpend = 0; end
          else bcnt--;
        end
        if (af) begin rpend = 1; raddr = cap_r; rcnt = 2; end
        if (rf) begin m_rvalid = 1'b0; m_rdata = '0; end
        if (rpend && !mute_r) begin
          if (rcnt == 0) begin
            m_rvalid = 1'b1; m_rresp = 2'b00; rpend = 0;
            m_rdata = mem.exists(raddr) ? mem[raddr] : 32'h0;
          end else rcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT handshake and checks isolation each cycle.
  initial begin
    a_t e;
    r_t r;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (rst) inflight = 0;
      else begin
        if (busy) begin
          for (int i = 0; i < 2; i++)
            if (i != int'(grant_id))
              chk($sformatf("ungranted%0d_quiet", i),
                  64'({s_awready[i], s_wready[i], s_arready[i], s_bvalid[i], s_rvalid[i]}), 64'd0);
        end else begin
          chk("idle_s_quiet", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 64'd0);
          if (m_bvalid) chk("idle_absorbs_b", 64'(m_bready), 64'd1);
        end
        if (m_awvalid && m_awready) begin
          aw_cnt++; a_hs_cyc = cyc;
          chk("aw_no_overlap", 64'(inflight), 64'd0);
          inflight = 1;
          chk("aw_expected", 64'(exp_a.size() != 0), 64'd1);
          if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            chk("aw_op_order", 64'(e.is_rd), 64'd0);
            chk("aw_grant", 64'(grant_id), 64'(e.gid));
            chk("aw_addr", 64'(m_awaddr), 64'(e.addr));
          end
        end
        if (m_wvalid && m_wready) begin
          w_cnt++; a_hs_cyc = cyc;
          chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
          if (exp_w.size() != 0) begin
            d = exp_w.pop_front();
            chk("w_data", 64'(m_wdata), 64'(d));
            chk("w_strb", 64'(m_wstrb), 64'hf);
          end
        end
        if (m_arvalid && m_arready) begin
          a_hs_cyc = cyc;
          chk("ar_no_overlap", 64'(inflight), 64'd0);
          inflight = 1;
          chk("ar_expected", 64'(exp_a.size() != 0), 64'd1);
          if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            chk("ar_op_order", 64'(e.is_rd), 64'd1);
            chk("ar_grant", 64'(grant_id), 64'(e.gid));
            chk("ar_addr", 64'(m_araddr), 64'(e.addr));
          end
        end
        for (int i = 0; i < 2; i++) begin
          if ((s_bvalid[i] && s_bready[i]) || (s_rvalid[i] && s_rready[i])) begin
            resp_cnt++; resp_delay = cyc - a_hs_cyc; inflight = 0;
            chk("resp_expected", 64'(exp_r.size() != 0), 64'd1);
            if (exp_r.size() != 0) begin
              r = exp_r.pop_front();
              chk("resp_requester", 64'(i), 64'(r.id));
              chk("resp_kind", 64'(s_rvalid[i]), 64'(r.is_rd));
              if (r.is_rd) begin
                chk("rresp", 64'(s_rresp[i*2 +: 2]), 64'(r.resp));
                chk("rdata", 64'(s_rdata[i*32 +: 32]), 64'(r.data));
              end else chk("bresp", 64'(s_bresp[i*2 +: 2]), 64'(r.resp));
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0;
    s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_bready = 2'b11; s_rready = 2'b11;

    // Single write: one-cycle request-to-m_awvalid latency, s1 stays quiet.
    do_reset();
    exp_wr(0, 32'h50000000, 32'h11000011, 2'b00);
    fork
      req(0, 1, 0, 32'h50000000, 32'h11000011, 32'h0, 0);
      begin
        @(negedge clk);
        chk("lat_cycle_k_awvalid", 64'(m_awvalid), 64'd0);
        @(negedge clk);
        chk("lat_cycle_k1_awvalid", 64'(m_awvalid), 64'd1);
        chk("lat_cycle_k1_awaddr", 64'(m_awaddr), 64'h50000000);
        chk("lat_cycle_k1_wdata", 64'(m_wdata), 64'h11000011);
        chk("s1_readies", 64'({s_awready[1], s_wready[1], s_arready[1]}), 64'd0);
      end
    join
    wait_idle();

    // Simultaneous writes: s0 then s1.
    do_reset();
    exp_wr(0, 32'h50000100, 32'hA0A0A0A0, 2'b00);
    exp_wr(1, 32'h50000200, 32'hB1B1B1B1, 2'b00);
    fork
      req(0, 1, 0, 32'h50000100, 32'hA0A0A0A0, 32'h0, 0);
      req(1, 1, 0, 32'h50000200, 32'hB1B1B1B1, 32'h0, 0);
    join
    wait_idle();

    // s1 read arrives while s0 write waits for its response.
    do_reset();
    exp_wr(0, 32'h50000008, 32'h33333333, 2'b00);
    exp_rd(1, 32'h50000004, 32'h22000022, 2'b00);
    fork
      req(0, 1, 0, 32'h50000008, 32'h33333333, 32'h0, 0);
      begin repeat (2) @(posedge clk); req(1, 0, 1, 32'h0, 32'h0, 32'h50000004, 0); end
    join
    wait_idle();

    // AW+AR together twice from s0: write, read, write, read.
    do_reset();
    exp_wr(0, 32'h50000010, 32'h44444444, 2'b00);
    exp_rd(0, 32'h50000010, 32'h44444444, 2'b00);
    req(0, 1, 1, 32'h50000010, 32'h44444444, 32'h50000010, 0);
    wait_idle();
    exp_wr(0, 32'h50000014, 32'h66666666, 2'b00);
    exp_rd(0, 32'h50000010, 32'h44444444, 2'b00);
    req(0, 1, 1, 32'h50000014, 32'h66666666, 32'h50000010, 0);
    wait_idle();

    // After one completed write the preference flips: read goes first and sees the old value.
    do_reset();
    exp_wr(0, 32'h50000030, 32'h0000000A, 2'b00);
    req(0, 1, 0, 32'h50000030, 32'h0000000A, 32'h0, 0);
    wait_idle();
    exp_rd(0, 32'h50000030, 32'h0000000A, 2'b00);
    exp_wr(0, 32'h50000030, 32'h0000000B, 2'b00);
    req(0, 1, 1, 32'h50000030, 32'h0000000B, 32'h50000030, 0);
    wait_idle();

    // W leads AW by three cycles.
    do_reset();
    exp_wr(0, 32'h50000040, 32'h55555555, 2'b00);
    req(0, 1, 0, 32'h50000040, 32'h55555555, 32'h0, 3);
    wait_idle();
    chk("wlead_aw_handshakes", 64'(aw_cnt), 64'd1);
    chk("wlead_w_handshakes", 64'(w_cnt), 64'd1);
    chk("wlead_responses", 64'(resp_cnt), 64'd1);

    // Silent MNA: SLVERR 18 cycles after the last address/data handshake, late bvalid absorbed.
    do_reset();
    mute_b = 1;
    exp_wr(0, 32'h50000050, 32'h77777777, 2'b10);
    req(0, 1, 0, 32'h50000050, 32'h77777777, 32'h0, 0);
    wait_idle();
    chk("timeout_delay", 64'(resp_delay), 64'd18);
    mute_b = 0;
    repeat (6) @(negedge clk);
    chk("late_b_absorbed", 64'(m_bvalid), 64'd0);
    chk("late_b_not_forwarded", 64'(s_bvalid), 64'd0);
    chk("late_b_resp_count", 64'(resp_cnt), 64'd1);

    // Reset while s1 waits in RD_R.
    mute_r = 1;
    exp_a.push_back('{1'b1, 1, 32'h50000004});
    req(1, 0, 1, 32'h0, 32'h0, 32'h50000004, 0);
    s_arvalid = '0;
    repeat (2) @(negedge clk);
    chk("rdr_busy_before_rst", 64'({busy, grant_id}), 64'b11);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_grant", 64'(grant_id), 64'd0);
    chk("midrst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    mute_r = 0;
    repeat (4) @(negedge clk);
    chk("queues_empty", 64'(exp_a.size() + exp_w.size() + exp_r.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
